hash_table_arbiter: RTL and testbench

- Shares the hash table pipeline between NUM_REQ independent requesters: round-robin arbitration, key-hazard blocking and response routing.
- Sits directly in front of the hash table.
  - Issues one op word per cycle into the table's data_in/valid_i.
  - Tracks every in-flight op by requester ID so that each table result returns to the requester that issued it.

---
 rtl/hash_table_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/hash_table_arbiter.sv | 134 +++++++++++++
 tb/tb_hash_table_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// Shared types for the hash table arbiter: op encoding, tracker entry and hazard helpers.
package hash_table_pkg;

  // Op field position, counted down from the op word MSB.
  localparam int unsigned OP_MSB    = 0;
  localparam int unsigned OP_LSB    = 1;
  localparam int unsigned KEY_W_MAX = 32;
  localparam int unsigned ID_W_MAX  = 8;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_READ   = 2'b01,
    OP_WRITE  = 2'b10,
    OP_DELETE = 2'b11
  } op_t;

  typedef struct packed {
    logic                 valid;
    op_t                  op;
    logic [KEY_W_MAX-1:0] key;
    logic [ID_W_MAX-1:0]  id;
  } tracker_entry_t;

  function automatic logic is_modify(input op_t op);
    return (op == OP_WRITE) || (op == OP_DELETE);
  endfunction

  // Same key is a hazard unless both sides are plain reads.
  function automatic logic key_hazard(input tracker_entry_t e, input op_t op,
                                      input logic [KEY_W_MAX-1:0] key);
    return e.valid && (e.key == key) && (is_modify(e.op) || is_modify(op));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr_i wins; pointer moves past the winner.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] next_ptr_o
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o      = '0;
    next_ptr_o = ptr_i;
    idx        = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        next_ptr_o = (32'(idx) == N - 1) ? '0 : IW'(32'(idx) + 1);
      end
    end
  end

endmodule

// File: rtl/hash_table_arbiter.sv
// Shares one hash table pipeline between NUM_REQ requesters: round-robin issue,
// key-hazard blocking, and routing of each table result back to its issuer.
module hash_table_arbiter
  import hash_table_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEY_WIDTH  = 16,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          ht_ready_i,
  output logic                          ht_valid_o,
  output logic [DATA_WIDTH-1:0]         ht_data_o,
  input  logic                          ht_valid_i,
  input  logic [DATA_WIDTH-1:0]         ht_rdata_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          err_o
);

  localparam int unsigned IW    = $clog2(NUM_REQ);
  localparam int unsigned OP_FW = OP_LSB - OP_MSB + 1;
  localparam int unsigned OP_LO = DATA_WIDTH - 1 - OP_LSB;

  logic [IW-1:0]         ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    elig, gnt;
  tracker_entry_t        iss_q, iss_d;
  tracker_entry_t        trk_q [PIPE_DEPTH];
  logic [DATA_WIDTH-1:0] ht_data_q, ht_data_d, win_word;
  logic [ID_W_MAX-1:0]   win_id;
  op_t                   req_op, win_op;
  logic [KEY_W_MAX-1:0]  req_key;
  logic                  hazard;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  err_q;

  // Hazard check against the op sitting in the issue register and every tracker slot.
  always_comb begin
    elig    = '0;
    req_op  = OP_NOP;
    req_key = '0;
    hazard  = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_op  = op_t'(req_data_i[r*DATA_WIDTH + OP_LO +: OP_FW]);
      req_key = KEY_W_MAX'(req_data_i[r*DATA_WIDTH +: KEY_WIDTH]);
      hazard  = key_hazard(iss_q, req_op, req_key);
      for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
        hazard = hazard | key_hazard(trk_q[s], req_op, req_key);
      end
      elig[r] = !reset && ht_ready_i && req_valid_i[r] && !hazard;
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i      (elig),
    .ptr_i      (ptr_q),
    .gnt_o      (gnt),
    .next_ptr_o (ptr_d)
  );

  assign req_ready_o = gnt;

  // Winner mux and issue-register next state; NOPs are consumed but never issued.
  always_comb begin
    win_word  = '0;
    win_id    = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (gnt[r]) begin
        win_word = req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
        win_id   = ID_W_MAX'(r);
      end
    end
    win_op    = op_t'(win_word[OP_LO +: OP_FW]);
    iss_d     = iss_q;
    ht_data_d = ht_data_q;
    if (ht_ready_i) begin
      iss_d = '0;
      if ((|gnt) && (win_op != OP_NOP)) begin
        iss_d.valid = 1'b1;
        iss_d.op    = win_op;
        iss_d.key   = KEY_W_MAX'(win_word[KEY_WIDTH-1:0]);
        iss_d.id    = win_id;
        ht_data_d   = win_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      iss_q       <= '0;
      ht_data_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
        trk_q[s] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      iss_q       <= iss_d;
      ht_data_q   <= ht_data_d;
      rsp_valid_q <= '0;
      // The table advances only with ht_ready_i, so results are consumed on the same condition.
      if (ht_ready_i) begin
        trk_q[0] <= iss_q;
        for (int unsigned s = 1; s < PIPE_DEPTH; s++) begin
          trk_q[s] <= trk_q[s-1];
        end
        if (ht_valid_i) begin
          if (trk_q[PIPE_DEPTH-1].valid) begin
            rsp_valid_q[trk_q[PIPE_DEPTH-1].id[IW-1:0]] <= 1'b1;
            rsp_data_q <= ht_rdata_i;
          end else begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign ht_valid_o  = iss_q.valid;
  assign ht_data_o   = ht_data_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Directed bench for hash_table_arbiter with a behavioural PIPE_DEPTH-stage hash table model.
module tb_hash_table_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned PD = 2;
  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] RD  = 2'b01;
  localparam logic [1:0] WR  = 2'b10;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready_o;
  logic             ht_ready;
  logic             ht_valid_o;
  logic [DW-1:0]    ht_data_o;
  logic             ht_valid_i;
  logic [DW-1:0]    ht_rdata_i;
  logic [NR-1:0]    rsp_valid_o;
  logic [DW-1:0]    rsp_data_o;
  logic             err_o;
  logic             inj;

  int n_chk  = 0;
  int n_pass = 0;

  hash_table_arbiter #(.DATA_WIDTH(DW), .KEY_WIDTH(16), .NUM_REQ(NR), .PIPE_DEPTH(PD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready_o),
    .ht_ready_i  (ht_ready),
    .ht_valid_o  (ht_valid_o),
    .ht_data_o   (ht_data_o),
    .ht_valid_i  (ht_valid_i),
    .ht_rdata_i  (ht_rdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // Table model: READ returns the stored value or key+0x100, WRITE stores and echoes its payload.
  logic          tv [PD];
  logic [DW-1:0] td [PD];
  logic          mv [16];
  logic [DW-1:0] md [16];

  function automatic logic [DW-1:0] tbl_result(input logic [DW-1:0] word);
    logic [3:0] k;
    k = word[3:0];
    case (word[31:30])
      RD:      return mv[k] ? md[k] : 32'h100 + 32'(word[15:0]);
      WR:      return 32'(word[29:16]);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PD; i++) begin
        tv[i] <= 1'b0;
        td[i] <= '0;
      end
      for (int k = 0; k < 16; k++) begin
        mv[k] <= 1'b0;
        md[k] <= '0;
      end
    end else if (ht_ready) begin
      tv[0] <= ht_valid_o;
      td[0] <= tbl_result(ht_data_o);
      for (int i = 1; i < PD; i++) begin
        tv[i] <= tv[i-1];
        td[i] <= td[i-1];
      end
      if (ht_valid_o && ht_data_o[31:30] == WR) begin
        mv[ht_data_o[3:0]] <= 1'b1;
        md[ht_data_o[3:0]] <= 32'(ht_data_o[29:16]);
      end else if (ht_valid_o && ht_data_o[31:30] == 2'b11) begin
        mv[ht_data_o[3:0]] <= 1'b0;
      end
    end
  end

  assign ht_valid_i = (tv[PD-1] && ht_ready) || inj;
  assign ht_rdata_i = td[PD-1];

  function automatic logic [DW-1:0] w(input logic [1:0] op, input logic [13:0] pl,
                                      input logic [15:0] key);
    return {op, pl, key};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int r, input logic [DW-1:0] word);
    req_data[r*DW +: DW] = word;
  endtask

  // One clock cycle: drive ready/valids, then check grant (comb) and registered outputs.
  task automatic cyc(input string tag, input logic rdy, input logic [NR-1:0] v,
                     input logic [NR-1:0] e_gnt, input logic e_htv,
                     input logic [NR-1:0] e_rsp, input logic [DW-1:0] e_rdat);
    @(posedge clk); #1;
    ht_ready  = rdy;
    req_valid = v;
    #1;
    chk({tag, ".ready"},     64'(req_ready_o), 64'(e_gnt));
    chk({tag, ".ht_valid"},  64'(ht_valid_o),  64'(e_htv));
    chk({tag, ".rsp_valid"}, 64'(rsp_valid_o), 64'(e_rsp));
    chk({tag, ".rsp_data"},  64'(rsp_data_o),  64'(e_rdat));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = '1;
    ht_ready  = 1'b1;
    inj       = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".ready"},     64'(req_ready_o), 64'(0));
    chk({tag, ".ht_valid"},  64'(ht_valid_o),  64'(0));
    chk({tag, ".rsp_valid"}, 64'(rsp_valid_o), 64'(0));
    chk({tag, ".err"},       64'(err_o),       64'(0));
    reset     = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    ht_ready  = 1'b1;
    inj       = 1'b0;

    // Four READs to distinct keys: grants 0,1,2,3,0; responses 3 cycles after issue.
    for (int r = 0; r < NR; r++) set_req(r, w(RD, 14'h0, 16'(r + 1)));
    do_reset("rst0");
    cyc("rr.c0", 1'b1, 4'hF, 4'b0001, 1'b0, 4'b0000, 32'h0);
    cyc("rr.c1", 1'b1, 4'hF, 4'b0010, 1'b1, 4'b0000, 32'h0);
    chk("rr.c1.data", 64'(ht_data_o), 64'(w(RD, 14'h0, 16'h1)));
    cyc("rr.c2", 1'b1, 4'hF, 4'b0100, 1'b1, 4'b0000, 32'h0);
    chk("rr.c2.data", 64'(ht_data_o), 64'(w(RD, 14'h0, 16'h2)));
    cyc("rr.c3", 1'b1, 4'hF, 4'b1000, 1'b1, 4'b0000, 32'h0);
    cyc("rr.c4", 1'b1, 4'hF, 4'b0001, 1'b1, 4'b0001, 32'h101);
    cyc("rr.c5", 1'b1, 4'h0, 4'b0000, 1'b1, 4'b0010, 32'h102);
    chk("rr.c5.data", 64'(ht_data_o), 64'(w(RD, 14'h0, 16'h1)));
    cyc("rr.c6", 1'b1, 4'h0, 4'b0000, 1'b0, 4'b0100, 32'h103);
    cyc("rr.c7", 1'b1, 4'h0, 4'b0000, 1'b0, 4'b1000, 32'h104);
    cyc("rr.c8", 1'b1, 4'h0, 4'b0000, 1'b0, 4'b0001, 32'h101);

    // WRITE then READ on key 5: READ stalls until the WRITE has retired.
    set_req(0, w(WR, 14'h2A, 16'h5));
    set_req(1, w(RD, 14'h0, 16'h5));
    do_reset("rst1");
    cyc("haz.t0", 1'b1, 4'b0011, 4'b0001, 1'b0, 4'b0000, 32'h0);
    cyc("haz.t1", 1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0000, 32'h0);
    chk("haz.t1.data", 64'(ht_data_o), 64'(w(WR, 14'h2A, 16'h5)));
    cyc("haz.t2", 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000, 32'h0);
    cyc("haz.t3", 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000, 32'h0);
    cyc("haz.t4", 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0001, 32'h2A);
    cyc("haz.t5", 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 32'h2A);
    cyc("haz.t6", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h2A);
    cyc("haz.t7", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h2A);
    cyc("haz.t8", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 32'h2A);

    // READ after READ on key 7 issues back to back (pointer is at 2 here).
    set_req(0, w(RD, 14'h0, 16'h7));
    set_req(1, w(RD, 14'h0, 16'h7));
    cyc("rar.p0", 1'b1, 4'b0011, 4'b0001, 1'b0, 4'b0000, 32'h2A);
    cyc("rar.p1", 1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0000, 32'h2A);
    cyc("rar.p2", 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 32'h2A);
    cyc("rar.p3", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h2A);
    cyc("rar.p4", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0001, 32'h107);
    cyc("rar.p5", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 32'h107);

    // Three-cycle ht_ready stall mid-stream: issue holds, no grants, nothing lost.
    set_req(2, w(RD, 14'h0, 16'h9));
    set_req(3, w(RD, 14'h0, 16'hA));
    set_req(0, w(RD, 14'h0, 16'hB));
    cyc("stl.s0", 1'b1, 4'b1100, 4'b0100, 1'b0, 4'b0000, 32'h107);
    cyc("stl.s1", 1'b1, 4'b1000, 4'b1000, 1'b1, 4'b0000, 32'h107);
    cyc("stl.s2", 1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 32'h107);
    chk("stl.s2.data", 64'(ht_data_o), 64'(w(RD, 14'h0, 16'hA)));
    cyc("stl.s3", 1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 32'h107);
    cyc("stl.s4", 1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 32'h107);
    chk("stl.s4.data", 64'(ht_data_o), 64'(w(RD, 14'h0, 16'hA)));
    cyc("stl.s5", 1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0000, 32'h107);
    cyc("stl.s6", 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 32'h107);
    chk("stl.s6.data", 64'(ht_data_o), 64'(w(RD, 14'h0, 16'hB)));
    cyc("stl.s7", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0100, 32'h109);
    cyc("stl.s8", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1000, 32'h10A);
    cyc("stl.s9", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0001, 32'h10B);
    cyc("stl.s10", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h10B);

    // NOP from requester 2: granted, never issued, no response.
    set_req(2, w(NOP, 14'h0, 16'h3));
    cyc("nop.n0", 1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0000, 32'h10B);
    cyc("nop.n1", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h10B);
    cyc("nop.n2", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h10B);
    cyc("nop.n3", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h10B);
    cyc("nop.n4", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h10B);

    // Result with an empty tracker sets the sticky error until reset.
    @(posedge clk); #1;
    inj = 1'b1;
    #1;
    chk("err.before", 64'(err_o), 64'(0));
    @(posedge clk); #1;
    inj = 1'b0;
    #1;
    chk("err.set", 64'(err_o), 64'(1));
    chk("err.no_rsp", 64'(rsp_valid_o), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("err.sticky", 64'(err_o), 64'(1));
    end
    do_reset("rst2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
